// File: rtl/screen_sequencer.sv
// Game-flow controller: selects the active full-screen image, runs frame-synchronous
// fade-out/fade-in transitions between screens, and scales/blank-gates the RGB path.
module screen_sequencer #(
  parameter int FADE_STEP_FRAMES = 2,
  parameter int INTRO_FRAMES     = 180,
  parameter int END_FRAMES       = 240
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic       start_key,
  input  logic       player_dead,
  input  logic       stage_clear,
  input  logic [3:0] pix_red_in,
  input  logic [3:0] pix_green_in,
  input  logic [3:0] pix_blue_in,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic [2:0] screen_sel,
  output logic       game_run,
  output logic       frame_tick,
  output logic [3:0] fade_level
);

  localparam int STEP_W = (FADE_STEP_FRAMES < 2) ? 1 : $clog2(FADE_STEP_FRAMES);
  localparam logic [STEP_W-1:0] LP_STEP_LAST = STEP_W'(FADE_STEP_FRAMES - 1);
  localparam logic [15:0] LP_INTRO = 16'(INTRO_FRAMES);
  localparam logic [15:0] LP_END   = 16'(END_FRAMES);

  // Screen states share their encoding with screen_sel so a target maps straight across.
  typedef enum logic [2:0] {
    S_TITLE    = 3'd0,
    S_INTRO    = 3'd1,
    S_PLAY     = 3'd2,
    S_OVER     = 3'd3,
    S_CLEAR    = 3'd4,
    S_FADE_OUT = 3'd5,
    S_FADE_IN  = 3'd6
  } state_t;

  state_t            r_state, w_state_next;
  state_t            r_target, w_target_next;
  logic [2:0]        r_screen_sel, w_sel_next;
  logic [3:0]        r_fade, w_fade_next;
  logic [STEP_W-1:0] r_step, w_step_next;
  logic [15:0]       r_frame_cnt, w_cnt_next;
  logic [15:0]       w_cnt_inc;

  logic r_origin_d;
  logic r_frame_tick;
  logic r_start_prev;
  logic r_start_lat;
  logic r_dead_lat;
  logic r_clear_lat;
  logic w_origin;
  logic w_start_rise;

  assign w_origin     = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign w_start_rise = start_key & ~r_start_prev;
  assign w_cnt_inc    = (r_frame_cnt == 16'hFFFF) ? r_frame_cnt : r_frame_cnt + 16'd1;

  // Tick on the first cycle the raster origin is seen, so a stalled raster still gives one pulse.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_origin_d   <= 1'b0;
      r_frame_tick <= 1'b0;
      r_start_prev <= 1'b0;
    end else begin
      r_origin_d   <= w_origin;
      r_frame_tick <= w_origin & ~r_origin_d;
      r_start_prev <= start_key;
    end
  end

  // An event arriving in the tick cycle itself survives into the next frame.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start_lat <= 1'b0;
      r_dead_lat  <= 1'b0;
      r_clear_lat <= 1'b0;
    end else begin
      r_start_lat <= (r_start_lat & ~r_frame_tick) | w_start_rise;
      r_dead_lat  <= (r_dead_lat  & ~r_frame_tick) | player_dead;
      r_clear_lat <= (r_clear_lat & ~r_frame_tick) | stage_clear;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_TITLE;
      r_target     <= S_TITLE;
      r_screen_sel <= 3'd0;
      r_fade       <= 4'd15;
      r_step       <= '0;
      r_frame_cnt  <= 16'd0;
    end else begin
      r_state      <= w_state_next;
      r_target     <= w_target_next;
      r_screen_sel <= w_sel_next;
      r_fade       <= w_fade_next;
      r_step       <= w_step_next;
      r_frame_cnt  <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_target_next = r_target;
    w_sel_next    = r_screen_sel;
    w_fade_next   = r_fade;
    w_step_next   = r_step;
    w_cnt_next    = r_frame_cnt;
    if (r_frame_tick) begin
      case (r_state)
        S_TITLE: begin
          if (r_start_lat) begin
            w_state_next  = S_FADE_OUT;
            w_target_next = S_INTRO;
          end
        end
        S_INTRO: begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc >= LP_INTRO) begin
            w_state_next  = S_FADE_OUT;
            w_target_next = S_PLAY;
          end
        end
        S_PLAY: begin
          if (r_dead_lat) begin
            w_state_next  = S_FADE_OUT;
            w_target_next = S_OVER;
          end else if (r_clear_lat) begin
            w_state_next  = S_FADE_OUT;
            w_target_next = S_CLEAR;
          end
        end
        S_OVER: begin
          w_cnt_next = w_cnt_inc;
          if ((w_cnt_inc >= LP_END) || r_start_lat) begin
            w_state_next  = S_FADE_OUT;
            w_target_next = S_TITLE;
          end
        end
        S_CLEAR: begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc >= LP_END) begin
            w_state_next  = S_FADE_OUT;
            w_target_next = S_TITLE;
          end
        end
        S_FADE_OUT: begin
          if (r_fade == 4'd0) begin
            w_sel_next   = 3'(r_target);
            w_state_next = S_FADE_IN;
          end else if (r_step == LP_STEP_LAST) begin
            w_fade_next = r_fade - 4'd1;
            w_step_next = '0;
          end else begin
            w_step_next = r_step + 1'b1;
          end
        end
        S_FADE_IN: begin
          if (r_fade == 4'd15) begin
            w_state_next = r_target;
          end else if (r_step == LP_STEP_LAST) begin
            w_fade_next = r_fade + 4'd1;
            w_step_next = '0;
          end else begin
            w_step_next = r_step + 1'b1;
          end
        end
        default: begin
          w_state_next = S_TITLE;
        end
      endcase
      // Every state entry starts with fresh frame and fade-step counts.
      if (w_state_next != r_state) begin
        w_cnt_next  = 16'd0;
        w_step_next = '0;
      end
    end
  end

  logic [3:0] w_pix_in [3];
  assign w_pix_in[0] = pix_red_in;
  assign w_pix_in[1] = pix_green_in;
  assign w_pix_in[2] = pix_blue_in;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [7:0] w_prod;
      logic [3:0] r_chan_out;
      assign w_prod = {4'b0000, w_pix_in[gi]} * {4'b0000, r_fade};
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          r_chan_out <= 4'd0;
        end else if (!blank) begin
          r_chan_out <= 4'd0;
        end else if (r_fade == 4'd15) begin
          r_chan_out <= w_pix_in[gi];
        end else begin
          r_chan_out <= w_prod[7:4];
        end
      end
    end
  endgenerate

  assign red        = g_chan[0].r_chan_out;
  assign green      = g_chan[1].r_chan_out;
  assign blue       = g_chan[2].r_chan_out;
  assign screen_sel = r_screen_sel;
  assign game_run   = (r_state == S_PLAY);
  assign frame_tick = r_frame_tick;
  assign fade_level = r_fade;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer on a 16x4 virtual raster with short frame counts.
module tb_screen_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] DrawX = 10'd1;
  logic [9:0] DrawY = 10'd0;
  logic       blank = 1'b1;
  logic       start_key = 1'b0;
  logic       player_dead = 1'b0;
  logic       stage_clear = 1'b0;
  logic [3:0] pix_red_in = 4'd0;
  logic [3:0] pix_green_in = 4'd0;
  logic [3:0] pix_blue_in = 4'd0;
  logic [3:0] red, green, blue;
  logic [2:0] screen_sel;
  logic       game_run;
  logic       frame_tick;
  logic [3:0] fade_level;

  int n_vec = 0;
  int n_err = 0;

  screen_sequencer #(
    .FADE_STEP_FRAMES(1),
    .INTRO_FRAMES(4),
    .END_FRAMES(3)
  ) dut (
    .vga_clk(clk),
    .reset_n(reset_n),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .blank(blank),
    .start_key(start_key),
    .player_dead(player_dead),
    .stage_clear(stage_clear),
    .pix_red_in(pix_red_in),
    .pix_green_in(pix_green_in),
    .pix_blue_in(pix_blue_in),
    .red(red),
    .green(green),
    .blue(blue),
    .screen_sel(screen_sel),
    .game_run(game_run),
    .frame_tick(frame_tick),
    .fade_level(fade_level)
  );

  always #5 clk = ~clk;

  // 16x4 raster advanced away from the sampling edge of the DUT.
  always @(negedge clk) begin
    if (DrawX == 10'd15) begin
      DrawX = 10'd0;
      DrawY = (DrawY == 10'd3) ? 10'd0 : DrawY + 10'd1;
    end else begin
      DrawX = DrawX + 10'd1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("vec %0d %s obs=0x%0h exp=0x%0h", n_vec, tag, obs, exp);
  endtask

  // Returns one negedge after the next frame_tick, so state outputs already reflect that tick.
  task automatic next_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (frame_tick !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    assert (frame_tick === 1'b1) else begin
      n_err++;
      $error("FAIL tick_timeout: observed %0b expected 1 within 200 cycles", frame_tick);
    end
    @(negedge clk);
  endtask

  // Starts just after the tick that entered FADE_OUT; ends just after the target is entered.
  task automatic run_fade(input int tgt, input int hook);
    int prev_sel;
    prev_sel = int'(screen_sel);
    for (int i = 1; i <= 15; i++) begin
      next_tick();
      check($sformatf("fade_out_%0d", i), int'(fade_level), 15 - i);
      check($sformatf("fade_out_sel_%0d", i), int'(screen_sel), prev_sel);
      if (i == hook) begin
        pix_red_in = 4'hF; pix_green_in = 4'hA; pix_blue_in = 4'h3;
        check("pix_latency", int'(red), 0);
        @(negedge clk);
        check("pix_f_at_8", int'(red), 7);
        check("pix_a_at_8", int'(green), 5);
        check("pix_3_at_8", int'(blue), 1);
        blank = 1'b0;
        @(negedge clk);
        check("pix_blank_r", int'(red), 0);
        check("pix_blank_g", int'(green), 0);
        blank = 1'b1;
        pix_red_in = 4'h0; pix_green_in = 4'h0; pix_blue_in = 4'h0;
        start_key = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start_key = 1'b0;
      end
    end
    next_tick();
    check("fade_bottom_sel", int'(screen_sel), tgt);
    check("fade_bottom_lvl", int'(fade_level), 0);
    for (int i = 1; i <= 15; i++) begin
      next_tick();
      check($sformatf("fade_in_%0d", i), int'(fade_level), i);
    end
    next_tick();
    check("enter_fade", int'(fade_level), 15);
    check("enter_sel", int'(screen_sel), tgt);
    check("enter_run", int'(game_run), (tgt == 2) ? 1 : 0);
  endtask

  initial begin
    int ticks;
    repeat (3) @(negedge clk);
    check("rst_sel", int'(screen_sel), 0);
    check("rst_fade", int'(fade_level), 15);
    check("rst_red", int'(red), 0);
    check("rst_run", int'(game_run), 0);
    check("rst_tick", int'(frame_tick), 0);
    reset_n = 1'b1;

    ticks = 0;
    repeat (192) begin
      @(negedge clk);
      if (frame_tick === 1'b1) ticks++;
    end
    check("idle_tick_count", ticks, 3);
    check("idle_sel", int'(screen_sel), 0);
    check("idle_fade", int'(fade_level), 15);

    next_tick();
    pix_red_in = 4'hF; pix_green_in = 4'hA; pix_blue_in = 4'h3;
    @(negedge clk);
    check("pix_full_r", int'(red), 15);
    check("pix_full_g", int'(green), 10);
    check("pix_full_b", int'(blue), 3);
    pix_red_in = 4'h0; pix_green_in = 4'h0; pix_blue_in = 4'h0;

    // TITLE -> INTRO, with pixel checks and a stray start press at fade 8.
    start_key = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start_key = 1'b0;
    next_tick();
    check("title_exit_fade", int'(fade_level), 15);
    check("title_exit_sel", int'(screen_sel), 0);
    run_fade(1, 7);

    // INTRO held four frames, the fourth tick starts the fade.
    for (int i = 1; i <= 4; i++) begin
      next_tick();
      check($sformatf("intro_hold_%0d", i), int'(fade_level), 15);
    end
    run_fade(2, -1);
    check("play_run", int'(game_run), 1);

    player_dead = 1'b1;
    stage_clear = 1'b1;
    @(negedge clk);
    player_dead = 1'b0;
    stage_clear = 1'b0;
    next_tick();
    check("play_exit_run", int'(game_run), 0);
    check("play_exit_sel", int'(screen_sel), 2);
    run_fade(3, -1);

    for (int i = 1; i <= 3; i++) begin
      next_tick();
      check($sformatf("over_hold_%0d", i), int'(fade_level), 15);
    end
    for (int i = 1; i <= 9; i++) begin
      next_tick();
      check($sformatf("over_fade_%0d", i), int'(fade_level), 15 - i);
    end
    pix_red_in = 4'hF;
    @(negedge clk);
    check("pix_f_at_6", int'(red), 5);

    reset_n = 1'b0;
    #1;
    check("midfade_rst_fade", int'(fade_level), 15);
    check("midfade_rst_sel", int'(screen_sel), 0);
    check("midfade_rst_red", int'(red), 0);
    check("midfade_rst_tick", int'(frame_tick), 0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_red", int'(red), 15);

    // stage_clear is meaningless on the title screen.
    next_tick();
    stage_clear = 1'b1;
    @(negedge clk);
    stage_clear = 1'b0;
    next_tick();
    next_tick();
    check("title_clear_ignored_fade", int'(fade_level), 15);
    check("title_clear_ignored_sel", int'(screen_sel), 0);

    start_key = 1'b1;
    @(negedge clk);
    start_key = 1'b0;
    next_tick();
    next_tick();
    check("restart_fade", int'(fade_level), 14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
